wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that sits directly upstream of the 16 × 16-bit register file. It accepts results from two producers, the ALU and the load unit, over valid/ready handshakes. Load results are buffered in a small FIFO. The block issues at most one registered write per cycle onto the register file's single write port (writeEnable/writeAddr/writeData). Optionally, it forwards the in-flight write onto the two read ports.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (16 registers)
- MEM_FIFO_DEPTH, 2, load-result FIFO entries (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- aluValid  in  1  ALU result present
- aluReady  out  1  ALU result accepted this cycle when aluValid & aluReady
- aluAddr  in  ADDR_W  ALU destination register
- aluData  in  DATA_W  ALU result
- memValid  in  1  load result present
- memReady  out  1  load result accepted when memValid & memReady
- memAddr  in  ADDR_W  load destination register
- memData  in  DATA_W  load result
- writeEnable  out  1  register file write strobe
- writeAddr  out  ADDR_W  register file write address
- writeData  out  DATA_W  register file write data
- readAddr1, readAddr2  in  ADDR_W  register file read addresses (shared with the register file)
- rfData1, rfData2  in  DATA_W  raw register file read data
- readData1, readData2  out  DATA_W  read data delivered to the consumer

## Operation
- memReady = FIFO not full. Load results enter the FIFO unconditionally when accepted.
- Arbitration each cycle:
  - FIFO full: the FIFO head wins the slot, and aluReady = 0.
  - FIFO not full: the ALU wins if aluValid. Otherwise a non-empty FIFO pops its head.
- aluReady = !fifoFull. An ALU result is never buffered; it goes straight to the output register.
- The output register loads the winner each cycle. writeEnable = 1 only if a winner existed.
- All 16 registers are writable, including register 0. There is no zero-register suppression.
- The producers are independent. Write-after-write ordering between ALU and load to the same register is the issuing stage's responsibility; this block preserves order only within each source.
- Simultaneous FIFO push and pop in the same cycle is legal at any occupancy. When full, a pop frees a slot only in the next cycle, because memReady is computed from the current count.

## Timing
- Reset values: writeEnable = 0, writeAddr = 0, writeData = 0, FIFO empty (count 0, pointers 0).
- While in reset: memReady = 1, aluReady = 1. All acceptances are discarded.
- Reset asserted mid-operation flushes FIFO contents and any pending write. No write strobe follows deassertion.
- Latency:
  - ALU accepted at edge N → writeEnable high during cycle N+1 → register file commits at edge N+1.
  - A load that wins the slot from an empty FIFO takes one cycle longer, because it must be pushed first.
- Throughput: one write per cycle sustained.
- FIFO pointers wrap modulo MEM_FIFO_DEPTH. The count saturates at MEM_FIFO_DEPTH and never overflows or underflows.

## Configuration
- WB_BYPASS_EN defined:
  - readDataX = writeData when writeEnable && writeAddr == readAddrX. Otherwise readDataX = rfDataX.
  - Purely combinational from the output register. This gives same-cycle visibility of the write being committed.
- WB_BYPASS_EN undefined: readDataX = rfDataX, and the read-side ports carry no logic.

## Structure
- Shared package wb_pkg holds:
  - DATA_W and ADDR_W constants.
  - typedef wb_req_t {addr, data}, used for the FIFO entry and the output register.
- One sub-module, wb_fifo: a parameterised synchronous FIFO of wb_req_t with push/pop/full/empty, async active-low reset.
- Arbitration, the output register and the bypass mux live in wb_arbiter.

## Test plan
- ALU only: aluValid with r2 = 0x1234 at edge N → writeEnable = 1, writeAddr = 2, writeData = 0x1234 in cycle N+1; idle afterwards → writeEnable = 0.
- Simultaneous: ALU r3 = 0xAAAA and load r0 = 0xABCD in the same cycle → r3 is written first, r0 in the following cycle; memReady stays 1.
- FIFO full: hold aluValid high while pushing three loads → memReady drops when count = 2, aluReady drops, the loads drain in order, then the ALU resumes.
- Reset mid-operation: FIFO holding two entries, rst_n pulsed low → writeEnable = 0 immediately, no stale write after release, FIFO empty.
- Bypass (WB_BYPASS_EN): writeEnable with r2 = 0x1234, readAddr1 = 2, rfData1 = 0x0000 → readData1 = 0x1234. Without the macro → readData1 = 0x0000.
- Wrap-around: 10 back-to-back loads to r0…r9 with no ALU traffic → 10 consecutive writes in order, correct data, pointers wrap cleanly.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the write-request record used by the writeback arbiter
// and its load-result FIFO.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage : wb_pkg

// File: rtl/wb_arbiter_if.sv
// Producer handshakes, register-file write port and read-port signals of the
// writeback arbiter. The slave modport is the arbiter side.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              aluValid;
  logic              aluReady;
  logic [ADDR_W-1:0] aluAddr;
  logic [DATA_W-1:0] aluData;

  logic              memValid;
  logic              memReady;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;

  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;

  logic [ADDR_W-1:0] readAddr1;
  logic [ADDR_W-1:0] readAddr2;
  logic [DATA_W-1:0] rfData1;
  logic [DATA_W-1:0] rfData2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;

  modport slave (
    input  aluValid, aluAddr, aluData,
    input  memValid, memAddr, memData,
    input  readAddr1, readAddr2, rfData1, rfData2,
    output aluReady, memReady,
    output writeEnable, writeAddr, writeData,
    output readData1, readData2
  );

  modport master (
    output aluValid, aluAddr, aluData,
    output memValid, memAddr, memData,
    output readAddr1, readAddr2, rfData1, rfData2,
    input  aluReady, memReady,
    input  writeEnable, writeAddr, writeData,
    input  readData1, readData2
  );

endinterface : wb_arbiter_if

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write requests; DEPTH must be a power of two so the
// pointers wrap naturally. Push when full and pop when empty are ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t            mem_q [DEPTH];
  wb_req_t            mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push_s;
  logic               do_pop_s;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == {CNT_W{1'b0}});
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : wb_fifo

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results bypass the queue, load results are buffered,
// one registered write per cycle. Define WB_BYPASS_EN for read-port forwarding.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  wb_arbiter_if.slave bus
);

  wb_req_t fifo_head_s;
  wb_req_t push_req_s;
  logic    fifo_full_s;
  logic    fifo_empty_s;
  logic    push_s;
  logic    pop_s;
  logic    alu_win_s;

  logic    we_q, we_d;
  wb_req_t req_q, req_d;

  wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_req_s),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // A full queue takes the slot so loads cannot be starved by the ALU.
  always_comb begin
    bus.aluReady = !fifo_full_s;
    bus.memReady = !fifo_full_s;
    push_req_s   = '{addr: bus.memAddr, data: bus.memData};
    push_s       = bus.memValid && !fifo_full_s;
    alu_win_s    = bus.aluValid && !fifo_full_s;
    pop_s        = fifo_full_s || (!bus.aluValid && !fifo_empty_s);
    we_d         = alu_win_s || pop_s;
    req_d        = req_q;
    if (alu_win_s) begin
      req_d = '{addr: bus.aluAddr, data: bus.aluData};
    end else if (pop_s) begin
      req_d = fifo_head_s;
    end else begin
      req_d = req_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      req_q <= '0;
    end else begin
      we_q  <= we_d;
      req_q <= req_d;
    end
  end

  assign bus.writeEnable = we_q;
  assign bus.writeAddr   = req_q.addr;
  assign bus.writeData   = req_q.data;

`ifdef WB_BYPASS_EN
  // Forward the write being committed this cycle onto matching read ports.
  always_comb begin
    if (we_q && (req_q.addr == bus.readAddr1)) begin
      bus.readData1 = req_q.data;
    end else begin
      bus.readData1 = bus.rfData1;
    end
    if (we_q && (req_q.addr == bus.readAddr2)) begin
      bus.readData2 = req_q.data;
    end else begin
      bus.readData2 = bus.rfData2;
    end
  end
`else
  assign bus.readData1 = bus.rfData1;
  assign bus.readData2 = bus.rfData2;
`endif

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations are hand-computed
// from the arbitration rules and adapt to WB_BYPASS_EN.
module tb_wb_arbiter;
  import wb_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .MEM_FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [3:0] a, input logic [15:0] d);
    check({tag, ".we"}, 32'(bus.writeEnable), 32'(we));
    if (we) begin
      check({tag, ".addr"}, 32'(bus.writeAddr), 32'(a));
      check({tag, ".data"}, 32'(bus.writeData), 32'(d));
    end
  endtask

  task automatic set_alu(input logic v, input logic [3:0] a, input logic [15:0] d);
    bus.aluValid = v;
    bus.aluAddr  = a;
    bus.aluData  = d;
  endtask

  task automatic set_mem(input logic v, input logic [3:0] a, input logic [15:0] d);
    bus.memValid = v;
    bus.memAddr  = a;
    bus.memData  = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    set_alu(1'b1, 4'd1, 16'hDEAD);
    set_mem(1'b1, 4'd1, 16'hBEEF);
    bus.readAddr1 = 4'd0;
    bus.readAddr2 = 4'd0;
    bus.rfData1   = 16'h0000;
    bus.rfData2   = 16'h0000;

    // Reset with both producers pushing: nothing may be accepted.
    tick();
    tick();
    check("rst.we", 32'(bus.writeEnable), 32'd0);
    check("rst.addr", 32'(bus.writeAddr), 32'd0);
    check("rst.data", 32'(bus.writeData), 32'd0);
    check("rst.memReady", 32'(bus.memReady), 32'd1);
    check("rst.aluReady", 32'(bus.aluReady), 32'd1);
    set_alu(1'b0, 4'd0, 16'h0000);
    set_mem(1'b0, 4'd0, 16'h0000);
    rst_n = 1'b1;
    tick();
    check_wr("post_rst", 1'b0, 4'd0, 16'h0000);

    // ALU only, plus bypass on port 1 and a non-matching port 2.
    set_alu(1'b1, 4'd2, 16'h1234);
    tick();
    set_alu(1'b0, 4'd0, 16'h0000);
    check_wr("alu", 1'b1, 4'd2, 16'h1234);
    bus.readAddr1 = 4'd2;
    bus.rfData1   = 16'h0000;
    bus.readAddr2 = 4'd5;
    bus.rfData2   = 16'h5555;
    #1;
    check("byp.rd1", 32'(bus.readData1), BYPASS ? 32'h1234 : 32'h0000);
    check("byp.rd2", 32'(bus.readData2), 32'h5555);
    tick();
    check_wr("alu_idle", 1'b0, 4'd0, 16'h0000);
    check("byp.rd1_idle", 32'(bus.readData1), 32'h0000);

    // Simultaneous ALU and load: ALU first, load next cycle.
    set_alu(1'b1, 4'd3, 16'hAAAA);
    set_mem(1'b1, 4'd0, 16'hABCD);
    #1;
    check("sim.memReady_pre", 32'(bus.memReady), 32'd1);
    tick();
    set_alu(1'b0, 4'd0, 16'h0000);
    set_mem(1'b0, 4'd0, 16'h0000);
    check_wr("sim.w1", 1'b1, 4'd3, 16'hAAAA);
    check("sim.memReady", 32'(bus.memReady), 32'd1);
    tick();
    check_wr("sim.w2", 1'b1, 4'd0, 16'hABCD);
    tick();
    check_wr("sim.idle", 1'b0, 4'd0, 16'h0000);

    // FIFO fills while the ALU is held busy.
    set_alu(1'b1, 4'd7, 16'h7777);
    set_mem(1'b1, 4'd4, 16'h4444);
    tick();
    check_wr("full.e1", 1'b1, 4'd7, 16'h7777);
    check("full.e1.memReady", 32'(bus.memReady), 32'd1);
    set_mem(1'b1, 4'd5, 16'h5555);
    tick();
    check_wr("full.e2", 1'b1, 4'd7, 16'h7777);
    check("full.e2.memReady", 32'(bus.memReady), 32'd0);
    check("full.e2.aluReady", 32'(bus.aluReady), 32'd0);
    set_mem(1'b1, 4'd6, 16'h6666);
    tick();
    check_wr("full.e3", 1'b1, 4'd4, 16'h4444);
    check("full.e3.aluReady", 32'(bus.aluReady), 32'd1);
    tick();
    set_mem(1'b0, 4'd0, 16'h0000);
    check_wr("full.e4", 1'b1, 4'd7, 16'h7777);
    check("full.e4.memReady", 32'(bus.memReady), 32'd0);
    tick();
    set_alu(1'b0, 4'd0, 16'h0000);
    check_wr("full.e5", 1'b1, 4'd5, 16'h5555);
    tick();
    check_wr("full.e6", 1'b1, 4'd6, 16'h6666);
    tick();
    check_wr("full.e7", 1'b0, 4'd0, 16'h0000);
    set_alu(1'b1, 4'd9, 16'h0909);
    tick();
    set_alu(1'b0, 4'd0, 16'h0000);
    check_wr("full.alu_resume", 1'b1, 4'd9, 16'h0909);

    // Reset mid-operation with two queued loads.
    set_alu(1'b1, 4'd1, 16'h1111);
    set_mem(1'b1, 4'd8, 16'h8888);
    tick();
    set_mem(1'b1, 4'd9, 16'h9999);
    tick();
    set_alu(1'b0, 4'd0, 16'h0000);
    set_mem(1'b0, 4'd0, 16'h0000);
    check("mid.full", 32'(bus.memReady), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid.we", 32'(bus.writeEnable), 32'd0);
    check("mid.memReady", 32'(bus.memReady), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check_wr("mid.post1", 1'b0, 4'd0, 16'h0000);
    tick();
    check_wr("mid.post2", 1'b0, 4'd0, 16'h0000);
    check("mid.aluReady", 32'(bus.aluReady), 32'd1);

    // Ten back-to-back loads exercise pointer wrap.
    for (int i = 0; i < 10; i++) begin
      set_mem(1'b1, 4'(i), 16'hC000 + 16'(i));
      tick();
      if (i == 0) begin
        check_wr("wrap.first", 1'b0, 4'd0, 16'h0000);
      end else begin
        check_wr($sformatf("wrap.%0d", i - 1), 1'b1, 4'(i - 1), 16'hC000 + 16'(i - 1));
      end
    end
    set_mem(1'b0, 4'd0, 16'h0000);
    tick();
    check_wr("wrap.9", 1'b1, 4'd9, 16'hC009);
    tick();
    check_wr("wrap.idle", 1'b0, 4'd0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_wb_arbiter
